// File: rtl/manta_bus_pkg.sv
// Shared register-bus types for the manta core chain and its arbiter.
// Tags carry a 3-bit index, enough for the 8-requester maximum.
package manta_bus_pkg;
    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;
    localparam int IDX_W      = 3;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data;
        logic                  rw;
        logic                  valid;
    } bus_txn_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending slot after last_i, wrapping.
import manta_bus_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);
    // Two ascending passes: indices above last_i first, then the wrap-around.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_vld_o && pend_i[i] && (i > int'(last_i))) begin
                gnt_vld_o = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_vld_o && pend_i[i] && (i <= int'(last_i))) begin
                gnt_vld_o = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Shares the register bus among NUM_REQ requesters, tags each issued
// transaction and routes the chain's echoed response back to its owner.
import manta_bus_pkg::*;

module bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int BUS_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BUS_ADDR_W*NUM_REQ-1:0] req_addr_i,
    input  logic [BUS_DATA_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_rw_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_pending_o,
    output logic [NUM_REQ-1:0]            req_overflow_o,
    output logic [BUS_ADDR_W-1:0]         addr_o,
    output logic [BUS_DATA_W-1:0]         data_o,
    output logic                          rw_o,
    output logic                          valid_o,
    input  logic [BUS_DATA_W-1:0]         data_i,
    input  logic                          rw_i,
    input  logic                          valid_i,
    output logic [BUS_DATA_W-1:0]         resp_data_o,
    output logic                          resp_rw_o,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic                          orphan_o
);
    bus_txn_t slot_q [NUM_REQ];
    bus_txn_t slot_d [NUM_REQ];
    bus_txn_t out_q, out_d;
    tag_t     tag_q [BUS_LATENCY+1];
    tag_t     tag_d [BUS_LATENCY+1];
    tag_t     tail;

    logic [NUM_REQ-1:0]    ovf_q, ovf_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0]    resp_vld_q, resp_vld_d;
    logic [BUS_DATA_W-1:0] resp_data_q, resp_data_d;
    logic                  resp_rw_q, resp_rw_d;
    logic                  orphan_q, orphan_d;

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) pend[i] = slot_q[i].valid;
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .pend_i    (pend),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign tail = tag_q[BUS_LATENCY];

    always_comb begin
        slot_d = slot_q;
        ovf_d  = '0;
        out_d  = '0;
        last_d = gnt_vld ? gnt_idx : last_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                out_d          = slot_q[i];
                slot_d[i].valid = 1'b0;
            end
            // A grant in the same cycle frees the slot, so the refill is legal.
            if (req_valid_i[i]) begin
                if (slot_q[i].valid && !gnt[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    slot_d[i].addr  = req_addr_i[BUS_ADDR_W*i +: BUS_ADDR_W];
                    slot_d[i].data  = req_data_i[BUS_DATA_W*i +: BUS_DATA_W];
                    slot_d[i].rw    = req_rw_i[i];
                    slot_d[i].valid = 1'b1;
                end
            end
        end

        tag_d[0].valid = gnt_vld;
        tag_d[0].idx   = gnt_idx;
        for (int s = 1; s <= BUS_LATENCY; s++) tag_d[s] = tag_q[s-1];

        resp_vld_d  = '0;
        resp_data_d = '0;
        resp_rw_d   = 1'b0;
        orphan_d    = valid_i && !tail.valid;
        if (valid_i && tail.valid) begin
            resp_data_d = data_i;
            resp_rw_d   = rw_i;
            for (int i = 0; i < NUM_REQ; i++)
                resp_vld_d[i] = (tail.idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
            for (int s = 0; s <= BUS_LATENCY; s++) tag_q[s] <= '0;
            out_q       <= '0;
            ovf_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ-1);
            resp_vld_q  <= '0;
            resp_data_q <= '0;
            resp_rw_q   <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            tag_q       <= tag_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            resp_rw_q   <= resp_rw_d;
            orphan_q    <= orphan_d;
        end
    end

    assign req_pending_o  = pend;
    assign req_overflow_o = ovf_q;
    assign addr_o         = out_q.addr;
    assign data_o         = out_q.data;
    assign rw_o           = out_q.rw;
    assign valid_o        = out_q.valid;
    assign resp_data_o    = resp_data_q;
    assign resp_rw_o      = resp_rw_q;
    assign resp_valid_o   = resp_vld_q;
    assign orphan_o       = orphan_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with NUM_REQ=2, BUS_LATENCY=1.
module tb_bus_arbiter;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [16*NR-1:0] req_addr_i = '0;
    logic [16*NR-1:0] req_data_i = '0;
    logic [NR-1:0] req_rw_i = '0;
    logic [NR-1:0] req_valid_i = '0;
    logic [NR-1:0] req_pending_o, req_overflow_o, resp_valid_o;
    logic [15:0]   addr_o, data_o, resp_data_o;
    logic          rw_o, valid_o, resp_rw_o, orphan_o;
    logic [15:0]   data_i = '0;
    logic          rw_i = 1'b0;
    logic          valid_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    bus_arbiter #(.NUM_REQ(NR), .BUS_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_rw_i(req_rw_i),
        .req_valid_i(req_valid_i), .req_pending_o(req_pending_o),
        .req_overflow_o(req_overflow_o), .addr_o(addr_o), .data_o(data_o),
        .rw_o(rw_o), .valid_o(valid_o), .data_i(data_i), .rw_i(rw_i),
        .valid_i(valid_i), .resp_data_o(resp_data_o), .resp_rw_o(resp_rw_o),
        .resp_valid_o(resp_valid_o), .orphan_o(orphan_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [15:0] a, input logic [15:0] d, input logic rw);
        req_valid_i[i] = 1'b1;
        req_addr_i[16*i +: 16] = a;
        req_data_i[16*i +: 16] = d;
        req_rw_i[i] = rw;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] cur [NR];

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_pend", 32'(req_pending_o), 0);
        chk("rst_out", {addr_o, data_o}, 0);
        chk("rst_resp", {resp_valid_o, orphan_o, req_overflow_o}, 0);
        rst = 1'b0;
        tick();

        // Single read from requester 0
        req(0, 16'h0003, 16'h0000, 1'b0);
        tick();
        req_valid_i = '0;
        chk("rd_pend", 32'(req_pending_o), 32'h1);
        chk("rd_noissue", 32'(valid_o), 0);
        tick();
        chk("rd_valid", 32'(valid_o), 1);
        chk("rd_addr", 32'(addr_o), 32'h3);
        chk("rd_rw", 32'(rw_o), 0);
        tick();
        chk("rd_idle", {valid_o, addr_o}, 0);
        valid_i = 1'b1; data_i = 16'h00AB; rw_i = 1'b0;
        tick();
        valid_i = 1'b0;
        chk("rd_resp_v", 32'(resp_valid_o), 32'h1);
        chk("rd_resp_d", 32'(resp_data_o), 32'hAB);
        chk("rd_orphan", 32'(orphan_o), 0);
        tick();
        chk("rd_resp_off", 32'(resp_valid_o), 0);

        // Fairness: both slots kept pending, expect strict alternation from 0
        do_reset();
        cur[0] = 16'h0100; cur[1] = 16'h0200;
        req(0, cur[0], 16'h1111, 1'b1);
        req(1, cur[1], 16'h2222, 1'b0);
        tick();
        req_valid_i = '0;
        for (int k = 0; k < 8; k++) begin
            int g;
            logic [15:0] na;
            g = k % 2;
            na = 16'h0100 * 16'(g + 1) + 16'(k + 1);
            req(g, na, 16'h0, 1'b0);
            tick();
            req_valid_i = '0;
            chk($sformatf("fair_v%0d", k), 32'(valid_o), 1);
            chk($sformatf("fair_a%0d", k), 32'(addr_o), 32'(cur[g]));
            chk($sformatf("fair_ovf%0d", k), 32'(req_overflow_o), 0);
            chk($sformatf("fair_pend%0d", k), 32'(req_pending_o), 32'h3);
            cur[g] = na;
        end
        tick();
        chk("fair_drain0", 32'(addr_o), 32'(cur[0]));
        tick();
        chk("fair_drain1", 32'(addr_o), 32'(cur[1]));
        chk("fair_orphan", 32'(orphan_o), 0);

        // Overflow on slot 1 while slot 0 wins; also route responses to both
        do_reset();
        req(0, 16'h0010, 16'h0, 1'b0);
        req(1, 16'h0004, 16'h0, 1'b0);
        tick();
        req_valid_i = '0;
        req(1, 16'h0005, 16'h0, 1'b0);
        tick();
        req_valid_i = '0;
        chk("ovf_a0", 32'(addr_o), 32'h10);
        chk("ovf_pulse", 32'(req_overflow_o), 32'h2);
        chk("ovf_pend", 32'(req_pending_o), 32'h2);
        tick();
        chk("ovf_a1", 32'(addr_o), 32'h4);
        chk("ovf_v1", 32'(valid_o), 1);
        chk("ovf_clr", 32'(req_overflow_o), 0);
        chk("ovf_pend0", 32'(req_pending_o), 0);
        valid_i = 1'b1; data_i = 16'h010A; rw_i = 1'b0;
        tick();
        chk("ovf_idle", 32'(valid_o), 0);
        chk("ovf_r0v", 32'(resp_valid_o), 32'h1);
        chk("ovf_r0d", 32'(resp_data_o), 32'h010A);
        data_i = 16'h004B; rw_i = 1'b1;
        tick();
        valid_i = 1'b0; rw_i = 1'b0;
        chk("ovf_r1v", 32'(resp_valid_o), 32'h2);
        chk("ovf_r1d", 32'(resp_data_o), 32'h4B);
        chk("ovf_r1rw", 32'(resp_rw_o), 1);
        tick();
        chk("ovf_r_off", {resp_valid_o, orphan_o, valid_o}, 0);

        // Same-slot grant and refill every cycle
        do_reset();
        req(0, 16'h0020, 16'h0, 1'b0);
        tick();
        for (int k = 1; k < 6; k++) begin
            req(0, 16'h0020 + 16'(k), 16'h0, 1'b0);
            tick();
            chk($sformatf("ref_v%0d", k), 32'(valid_o), 1);
            chk($sformatf("ref_a%0d", k), 32'(addr_o), 32'h20 + 32'(k - 1));
            chk($sformatf("ref_ovf%0d", k), 32'(req_overflow_o), 0);
        end
        req_valid_i = '0;
        tick();
        chk("ref_last", 32'(addr_o), 32'h25);
        tick();
        chk("ref_end", {valid_o, addr_o}, 0);
        chk("ref_noresp", 32'(resp_valid_o), 0);

        // Orphan response with empty tag pipe
        tick(); tick();
        valid_i = 1'b1; data_i = 16'h0055;
        tick();
        valid_i = 1'b0;
        chk("orph_pulse", 32'(orphan_o), 1);
        chk("orph_noresp", 32'(resp_valid_o), 0);
        tick();
        chk("orph_clr", 32'(orphan_o), 0);

        // Async reset between issue and response
        do_reset();
        req(0, 16'h0030, 16'h0, 1'b0);
        tick();
        req_valid_i = '0;
        tick();
        chk("ar_issue", 32'(valid_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_out0", {valid_o, addr_o, 16'(req_pending_o)}, 0);
        valid_i = 1'b1; data_i = 16'h0077;
        #1 rst = 1'b0;
        tick();
        valid_i = 1'b0;
        chk("ar_orphan", 32'(orphan_o), 1);
        chk("ar_noresp", 32'(resp_valid_o), 0);
        req(0, 16'h0031, 16'h0, 1'b0);
        tick();
        req_valid_i = '0;
        tick();
        chk("ar_new_v", 32'(valid_o), 1);
        chk("ar_new_a", 32'(addr_o), 32'h31);
        tick();
        valid_i = 1'b1; data_i = 16'h00CD;
        tick();
        valid_i = 1'b0;
        chk("ar_resp_v", 32'(resp_valid_o), 32'h1);
        chk("ar_resp_d", 32'(resp_data_o), 32'hCD);
        chk("ar_resp_orph", 32'(orphan_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the 16-bit addr/data/rw/valid register bus between NUM_REQ requesters: the host bridge_rx plus on-chip sequencers.
- Requesters issue single-cycle request pulses with no backpressure. The arbiter holds one pending request per requester and issues them onto the core chain in round-robin order.
- It tags every issued transaction and routes the chain's echoed response back to the requester that issued it.
- Sits between bridge_rx/local masters and the first core of the chain. Response routing takes the place of the chain's direct output-to-bridge_tx connection.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 is the host bridge.
- BUS_LATENCY, 1, fixed cycles from arbiter valid_o to chain valid_i (one per core in the chain, >=1).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- req_addr_i  in  16*NUM_REQ  request addresses; slice i = [16*i+15:16*i]
- req_data_i  in  16*NUM_REQ  write data per requester
- req_rw_i  in  NUM_REQ  1 = write, 0 = read
- req_valid_i  in  NUM_REQ  single-cycle request strobe
- req_pending_o  out  NUM_REQ  slot i holds an unissued request
- req_overflow_o  out  NUM_REQ  1-cycle pulse: request i dropped
- addr_o  out  16  bus address to chain
- data_o  out  16  bus data to chain
- rw_o  out  1  bus rw to chain
- valid_o  out  1  bus valid to chain
- data_i  in  16  chain response data
- rw_i  in  1  chain response rw
- valid_i  in  1  chain response valid
- resp_data_o  out  16  routed response data
- resp_rw_o  out  1  routed response rw
- resp_valid_o  out  NUM_REQ  one-hot response strobe to owner
- orphan_o  out  1  1-cycle pulse: response with no matching tag

Behaviour:
- All outputs are registered.
- Reset (async, rst=1):
  - clears slots, round-robin pointer (last grant = NUM_REQ-1, so requester 0 wins first) and tag pipe.
  - drives every output to 0.
  - Any request or response in flight is lost. A response arriving after reset has no tag, so orphan_o pulses.
- Capture:
  - req_valid_i[i] high at edge t loads slot i (addr, data, rw) and sets pending.
  - If slot i is already pending and not granted in that same cycle, the new request is dropped, the old one is kept, and req_overflow_o[i] pulses at t+1.
- Arbitration:
  - Each cycle, the grant goes to the first pending slot after last_grant, searching circularly in increasing index.
  - At most one grant per cycle. No grant is made when no slot is pending.
- Issue:
  - The granted slot drives addr_o/data_o/rw_o with valid_o=1 on the next edge, and its pending bit clears.
  - Best-case latency: request strobe cycle t, pending visible t+1, valid_o high t+2.
  - valid_o may be high on back-to-back cycles. addr_o/data_o/rw_o are 0 whenever valid_o=0.
- Simultaneous grant and new request on the same slot: the grant frees the slot and the new request is captured. No overflow.
- Tag pipe:
  - BUS_LATENCY+1 stages of {valid, idx[$clog2(NUM_REQ)-1:0]}, shifted every cycle.
  - Stage 0 loads {1, grant index} on issue and {0, x} otherwise.
  - The tail stage aligns with the chain's valid_i.
- Response:
  - valid_i=1 with tail valid: resp_valid_o[idx] pulses next cycle, and resp_data_o/resp_rw_o are registered from data_i/rw_i.
  - valid_i=1 with tail invalid: orphan_o pulses, no resp_valid_o.
  - Tail valid with valid_i=0: the chain dropped the transaction; it is silently discarded.
  - Write echoes (rw_i=1) are routed the same way as reads; requesters ignore them as they choose.
- Width rules: data passes unmodified; no arithmetic on address or data.

Decomposition:
- Package manta_bus_pkg:
  - BUS_ADDR_W = 16, BUS_DATA_W = 16
  - typedef bus_txn_t {addr, data, rw, valid}
  - typedef tag_t {valid, idx}
- Sub-module rr_arbiter (NUM_REQ): inputs pending vector and last_grant; outputs one-hot grant and grant index; purely combinational.
- Top-level bus_arbiter holds the slots, pointer, tag pipe and response routing.

Test Plan:
- Single read: req 0 pulses addr=0x0003, rw=0 at cycle 10 → valid_o=1 at cycle 12 with addr_o=0x0003. Chain echo data_i=0x00AB (BUS_LATENCY=1) → resp_valid_o=2'b01 and resp_data_o=0x00AB at cycle 14.
- Fairness: both slots held continuously pending by re-requesting every grant, for 8 issues → grant order 0,1,0,1,…; no requester gets two consecutive grants while the other is pending.
- Overflow: req 1 pulses addr=0x0004 at cycle 5 and addr=0x0005 at cycle 6 while slot 0 wins cycle 6 → req_overflow_o[1] pulses at cycle 7; addr 0x0004 is issued, 0x0005 never appears.
- Same-slot grant and refill: req 0 pulses every cycle, req 1 idle → valid_o high every cycle from cycle 2, addresses in order, no overflow.
- Orphan: valid_i=1 injected with tag pipe empty → orphan_o=1 for one cycle, resp_valid_o=0.
- Async reset mid-flight: rst asserted between a cycle-12 issue and its response (BUS_LATENCY=1) → all outputs 0 immediately; the late valid_i produces orphan_o, not resp_valid_o; after release, a new req 0 request completes normally.
